controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 266 ++++++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------------------
// controle_multiciclo
//
// Purpose:
//   Main control unit of a multi-cycle RISC-V style datapath. A Moore FSM
//   walks each instruction through IDLE -> FETCH -> DECODE -> EXECUTE and
//   then, depending on the instruction class, MEM and/or WRITEBACK before
//   going back to FETCH. Unknown opcodes, and memory accesses that never
//   complete within MEM_TIMEOUT cycles, park the FSM in TRAP until reset.
//
// Parameters:
//   ALUOP_W      width of aluOp (>= 2); only bits [1:0] are ever non-zero
//   EN_JUMP      1 = jal/jalr/lui/auipc accepted, 0 = they trap
//   MEM_TIMEOUT  wait cycles allowed for mem_ready; 0 = wait forever
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   instruction  opcode field of the instruction register
//   mem_ready    completion strobe for the current fetch or data access
//   pcWrite      PC update strobe (FETCH, in the cycle memory answers)
//   irWrite      IR load strobe   (FETCH, in the cycle memory answers)
//   branch       branch compare enable (EXECUTE, branch opcode)
//   jump         jump target select    (EXECUTE, jal/jalr)
//   memRead      memory read  (FETCH, or MEM for lw)
//   memWrite     memory write (MEM for sw)
//   memtoReg     register file takes memory data (WRITEBACK of lw)
//   aluSrc       ALU B operand is the immediate
//   regWrite     register file write enable (WRITEBACK only)
//   aluOp        ALU operation class
//   illegal      trap flag, held while the FSM sits in TRAP
//   state        current FSM state code
// ---------------------------------------------------------------------------
module controle_multiciclo #(
    parameter int ALUOP_W     = 2,
    parameter int EN_JUMP     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         instruction,
    input  logic               mem_ready,
    output logic               pcWrite,
    output logic               irWrite,
    output logic               branch,
    output logic               jump,
    output logic               memRead,
    output logic               memWrite,
    output logic               memtoReg,
    output logic               aluSrc,
    output logic               regWrite,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               illegal,
    output logic [2:0]         state
);

    // The wait counter must be able to hold MEM_TIMEOUT itself; keep at
    // least one bit so a disabled timeout still elaborates cleanly.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } stateT;

    stateT              r_state;
    stateT              w_nextState;
    logic [6:0]         r_opc;
    logic [CNT_W-1:0]   r_waitCnt;

    logic               w_jumpEn;
    logic               w_instrLegal;
    logic               w_waitExpired;
    logic               w_isR;
    logic               w_isLw;
    logic               w_isSw;
    logic               w_isBranch;
    logic               w_isImm;
    logic               w_isJal;
    logic               w_isJalr;
    logic               w_isLui;
    logic               w_isAuipc;
    logic [1:0]         w_aluOp2;

    // Opcode legality is judged on the live instruction while in DECODE,
    // because that is the cycle in which opc is being captured.
    function automatic logic isLegal(input logic [6:0] op, input logic jumpEn);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BRANCH, OP_IMM: isLegal = 1'b1;
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:     isLegal = jumpEn;
            default:                               isLegal = 1'b0;
        endcase
    endfunction

    assign w_jumpEn     = (EN_JUMP != 0);
    assign w_instrLegal = isLegal(instruction, w_jumpEn);

    // Instruction classes decoded from the captured opcode only, so the
    // datapath controls never follow a changing instruction input.
    assign w_isR      = (r_opc == OP_R);
    assign w_isLw     = (r_opc == OP_LW);
    assign w_isSw     = (r_opc == OP_SW);
    assign w_isBranch = (r_opc == OP_BRANCH);
    assign w_isImm    = (r_opc == OP_IMM);
    assign w_isJal    = w_jumpEn && (r_opc == OP_JAL);
    assign w_isJalr   = w_jumpEn && (r_opc == OP_JALR);
    assign w_isLui    = w_jumpEn && (r_opc == OP_LUI);
    assign w_isAuipc  = w_jumpEn && (r_opc == OP_AUIPC);

    // The timeout fires when the counter has already reached the limit and
    // memory still has not answered; a late mem_ready in that same cycle
    // takes priority in the next-state logic.
    assign w_waitExpired = (MEM_TIMEOUT > 0) &&
                           (r_waitCnt == CNT_W'(MEM_TIMEOUT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Opcode register, loaded once per instruction in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opc <= 7'd0;
        end else if (r_state == S_DECODE) begin
            r_opc <= instruction;
        end
    end

    // Wait counter for FETCH and MEM. Any state change clears it, which
    // covers entry into FETCH/MEM including the direct MEM -> FETCH step of
    // a store. While waiting it counts up and saturates, so a disabled
    // timeout cannot wrap into anything meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= '0;
        end else if (w_nextState != r_state) begin
            r_waitCnt <= '0;
        end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready
                     && (r_waitCnt != '1)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // Next-state logic. Code 6 and any other corrupted value fall back to
    // IDLE through the default branch.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                w_nextState = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_nextState = S_DECODE;
                end else if (w_waitExpired) begin
                    w_nextState = S_TRAP;
                end
            end
            S_DECODE: begin
                w_nextState = w_instrLegal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (w_isBranch) begin
                    w_nextState = S_FETCH;
                end else if (w_isLw || w_isSw) begin
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_nextState = w_isLw ? S_WRITEBACK : S_FETCH;
                end else if (w_waitExpired) begin
                    w_nextState = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                w_nextState = S_FETCH;
            end
            S_TRAP: begin
                w_nextState = S_TRAP;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Output decode. Everything depends on r_state/r_opc only, except the
    // IR/PC strobes which must coincide with the cycle memory delivers the
    // instruction word. MEM keeps the ALU setup of EXECUTE (lw/sw both use
    // the immediate with an add) so the address stays stable while waiting.
    always_comb begin
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memtoReg = 1'b0;
        aluSrc   = 1'b0;
        regWrite = 1'b0;
        illegal  = 1'b0;
        w_aluOp2 = 2'b00;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = mem_ready;
                pcWrite = mem_ready;
            end
            S_EXECUTE: begin
                if (w_isR) begin
                    w_aluOp2 = 2'b10;
                end else if (w_isBranch) begin
                    w_aluOp2 = 2'b01;
                end else if (w_isImm) begin
                    w_aluOp2 = 2'b11;
                end
                aluSrc = w_isLw || w_isSw || w_isImm || w_isJalr
                         || w_isLui || w_isAuipc;
                branch = w_isBranch;
                jump   = w_isJal || w_isJalr;
            end
            S_MEM: begin
                memRead  = w_isLw;
                memWrite = w_isSw;
                aluSrc   = w_isLw || w_isSw;
            end
            S_WRITEBACK: begin
                regWrite = 1'b1;
                memtoReg = w_isLw;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Upper aluOp bits are tied low by the zero extension.
    assign aluOp = ALUOP_W'(w_aluOp2);
    assign state = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_controle_multiciclo
//
// Two instances share clock and stimulus:
//   dutJ : EN_JUMP=1, MEM_TIMEOUT=15, ALUOP_W=3 (upper aluOp bit must be 0)
//   dutT : EN_JUMP=0, MEM_TIMEOUT=4,  ALUOP_W=2
// useT selects which instance the scoreboard observes.
// Expected output words are pushed when a cycle's stimulus is driven and
// popped/compared at the following falling edge.
// Word layout: {state[2:0], pcWrite, irWrite, branch, jump, memRead,
//               memWrite, memtoReg, aluSrc, regWrite, aluOp[2:0], illegal}
// ---------------------------------------------------------------------------
module tb_controle_multiciclo;

    localparam int P_FETCH = 0;
    localparam int P_LW    = 1;
    localparam int P_SW    = 2;
    localparam int P_WB    = 3;
    localparam int P_TRAP  = 4;

    typedef struct {
        logic [6:0] opc;
        logic [1:0] aop;
        logic       aSrc;
        logic       br;
        logic       jmp;
        int         path;
    } vecT;

    typedef struct {
        string       nm;
        logic [15:0] v;
    } sbT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  instruction = 7'd0;
    logic        mem_ready = 1'b0;
    logic        useT = 1'b0;

    logic        jPcWrite, jIrWrite, jBranch, jJump, jMemRead, jMemWrite;
    logic        jMemtoReg, jAluSrc, jRegWrite, jIllegal;
    logic [2:0]  jAluOp;
    logic [2:0]  jState;
    logic        tPcWrite, tIrWrite, tBranch, tJump, tMemRead, tMemWrite;
    logic        tMemtoReg, tAluSrc, tRegWrite, tIllegal;
    logic [1:0]  tAluOp;
    logic [2:0]  tState;

    logic [15:0] obsJ;
    logic [15:0] obsT;
    logic [15:0] obs;

    int          nAssert = 0;
    int          nFail = 0;
    sbT          expQ[$];
    vecT         vecs[11];

    always #5 clk = ~clk;

    controle_multiciclo #(.ALUOP_W(3), .EN_JUMP(1), .MEM_TIMEOUT(15)) dutJ (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .pcWrite(jPcWrite), .irWrite(jIrWrite), .branch(jBranch), .jump(jJump),
        .memRead(jMemRead), .memWrite(jMemWrite), .memtoReg(jMemtoReg),
        .aluSrc(jAluSrc), .regWrite(jRegWrite), .aluOp(jAluOp),
        .illegal(jIllegal), .state(jState)
    );

    controle_multiciclo #(.ALUOP_W(2), .EN_JUMP(0), .MEM_TIMEOUT(4)) dutT (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .pcWrite(tPcWrite), .irWrite(tIrWrite), .branch(tBranch), .jump(tJump),
        .memRead(tMemRead), .memWrite(tMemWrite), .memtoReg(tMemtoReg),
        .aluSrc(tAluSrc), .regWrite(tRegWrite), .aluOp(tAluOp),
        .illegal(tIllegal), .state(tState)
    );

    assign obsJ = {jState, jPcWrite, jIrWrite, jBranch, jJump, jMemRead, jMemWrite,
                   jMemtoReg, jAluSrc, jRegWrite, jAluOp, jIllegal};
    assign obsT = {tState, tPcWrite, tIrWrite, tBranch, tJump, tMemRead, tMemWrite,
                   tMemtoReg, tAluSrc, tRegWrite, 1'b0, tAluOp, tIllegal};
    assign obs  = useT ? obsT : obsJ;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic pcW,
                                       input logic irW, input logic br,
                                       input logic jmp, input logic mRd,
                                       input logic mWr, input logic m2r,
                                       input logic aSrc, input logic rW,
                                       input logic [2:0] aop, input logic ill);
        return {st, pcW, irW, br, jmp, mRd, mWr, m2r, aSrc, rW, aop, ill};
    endfunction

    function automatic logic [15:0] eIdle();
        return mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eFetch(input logic rdy);
        return mk(3'd1, rdy, rdy, 0, 0, 1, 0, 0, 0, 0, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eDecode();
        return mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eMemLw();
        return mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eMemSw();
        return mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eWb(input logic m2r);
        return mk(3'd5, 0, 0, 0, 0, 0, 0, m2r, 0, 1, 3'd0, 0);
    endfunction
    function automatic logic [15:0] eTrap();
        return mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1);
    endfunction

    // Pops the oldest expected word and compares it with the observed DUT.
    task automatic checkOutput();
        sbT item;
        nAssert++;
        if (expQ.size() == 0) begin
            nFail++;
            $display("[TB] FAIL scoreboard-empty: got state=%0d, required an expected entry",
                     obs[15:13]);
            return;
        end
        item = expQ.pop_front();
        if (obs !== item.v) begin
            nFail++;
            $display("[TB] FAIL %s: got state=%0d ctl=%b, required state=%0d ctl=%b",
                     item.nm, obs[15:13], obs[12:0], item.v[15:13], item.v[12:0]);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, records what the
    // outputs must be during that cycle and checks them at the falling edge.
    task automatic applyStimulus(input string nm, input logic [6:0] ins,
                                 input logic rdy, input logic [15:0] e);
        sbT item;
        instruction = ins;
        mem_ready   = rdy;
        item.nm = nm;
        item.v  = e;
        expQ.push_back(item);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks that it acts without a clock,
    // then releases it so the next cycle is IDLE.
    task automatic resetDut(input string nm);
        sbT item;
        @(posedge clk);
        #1;
        instruction = 7'd0;
        mem_ready   = 1'b0;
        rst = 1'b1;
        #1;
        item.nm = nm;
        item.v  = eIdle();
        expQ.push_back(item);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Standing properties on both instances every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            nAssert++;
            if ((jMemRead && jMemWrite) || (jRegWrite && jState != 3'd5)) begin
                nFail++;
                $display("[TB] FAIL invariantJ: got state=%0d memRead=%b memWrite=%b regWrite=%b, required exclusive mem strobes and regWrite only in state 5",
                         jState, jMemRead, jMemWrite, jRegWrite);
            end
            nAssert++;
            if ((tMemRead && tMemWrite) || (tRegWrite && tState != 3'd5)) begin
                nFail++;
                $display("[TB] FAIL invariantT: got state=%0d memRead=%b memWrite=%b regWrite=%b, required exclusive mem strobes and regWrite only in state 5",
                         tState, tMemRead, tMemWrite, tRegWrite);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required completion within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT v;
        sbT  item;

        vecs[0]  = '{7'b0110011, 2'b10, 1'b0, 1'b0, 1'b0, P_WB};
        vecs[1]  = '{7'b0000011, 2'b00, 1'b1, 1'b0, 1'b0, P_LW};
        vecs[2]  = '{7'b0100011, 2'b00, 1'b1, 1'b0, 1'b0, P_SW};
        vecs[3]  = '{7'b1100011, 2'b01, 1'b0, 1'b1, 1'b0, P_FETCH};
        vecs[4]  = '{7'b0010011, 2'b11, 1'b1, 1'b0, 1'b0, P_WB};
        vecs[5]  = '{7'b1101111, 2'b00, 1'b0, 1'b0, 1'b1, P_WB};
        vecs[6]  = '{7'b1100111, 2'b00, 1'b1, 1'b0, 1'b1, P_WB};
        vecs[7]  = '{7'b0110111, 2'b00, 1'b1, 1'b0, 1'b0, P_WB};
        vecs[8]  = '{7'b0010111, 2'b00, 1'b1, 1'b0, 1'b0, P_WB};
        vecs[9]  = '{7'b1111111, 2'b00, 1'b0, 1'b0, 1'b0, P_TRAP};
        vecs[10] = '{7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, P_TRAP};

        $display("[TB] start");

        // Opcode table on the jump-enabled instance. The instruction input is
        // inverted after DECODE so outputs must come from the captured opcode.
        useT = 1'b0;
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            resetDut($sformatf("v%0d-reset", i));
            applyStimulus($sformatf("v%0d-idle", i), 7'd0, 1'b0, eIdle());
            applyStimulus($sformatf("v%0d-fetch", i), 7'd0, 1'b1, eFetch(1'b1));
            applyStimulus($sformatf("v%0d-decode", i), v.opc, 1'b0, eDecode());
            if (v.path == P_TRAP) begin
                applyStimulus($sformatf("v%0d-trap", i), ~v.opc, 1'b1, eTrap());
                applyStimulus($sformatf("v%0d-trap-held", i), ~v.opc, 1'b0, eTrap());
            end else begin
                applyStimulus($sformatf("v%0d-execute", i), ~v.opc, 1'b0,
                              mk(3'd3, 0, 0, v.br, v.jmp, 0, 0, 0, v.aSrc, 0,
                                 {1'b0, v.aop}, 0));
                if (v.path == P_LW) begin
                    applyStimulus($sformatf("v%0d-mem", i), ~v.opc, 1'b1, eMemLw());
                    applyStimulus($sformatf("v%0d-wb", i), ~v.opc, 1'b0, eWb(1'b1));
                end else if (v.path == P_SW) begin
                    applyStimulus($sformatf("v%0d-mem", i), ~v.opc, 1'b1, eMemSw());
                end else if (v.path == P_WB) begin
                    applyStimulus($sformatf("v%0d-wb", i), ~v.opc, 1'b0, eWb(1'b0));
                end
                applyStimulus($sformatf("v%0d-refetch", i), 7'd0, 1'b0, eFetch(1'b0));
            end
        end

        // lw with a slow fetch and a data access answered after 3 wait cycles.
        resetDut("lw-reset");
        applyStimulus("lw-idle", 7'd0, 1'b0, eIdle());
        for (int k = 0; k < 2; k++) begin
            applyStimulus("lw-fetch-wait", 7'd0, 1'b0, eFetch(1'b0));
        end
        applyStimulus("lw-fetch", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("lw-decode", 7'b0000011, 1'b0, eDecode());
        applyStimulus("lw-execute", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0));
        for (int k = 0; k < 3; k++) begin
            applyStimulus("lw-mem-wait", 7'd0, 1'b0, eMemLw());
        end
        applyStimulus("lw-mem-done", 7'd0, 1'b1, eMemLw());
        applyStimulus("lw-wb", 7'd0, 1'b0, eWb(1'b1));
        applyStimulus("lw-refetch", 7'd0, 1'b0, eFetch(1'b0));

        // sw straight back to FETCH, then a branch.
        resetDut("swbr-reset");
        applyStimulus("swbr-idle", 7'd0, 1'b0, eIdle());
        applyStimulus("swbr-fetch-sw", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("swbr-decode-sw", 7'b0100011, 1'b0, eDecode());
        applyStimulus("swbr-exec-sw", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0));
        applyStimulus("swbr-mem-sw", 7'd0, 1'b1, eMemSw());
        applyStimulus("swbr-fetch-br", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("swbr-decode-br", 7'b1100011, 1'b0, eDecode());
        applyStimulus("swbr-exec-br", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 0));
        applyStimulus("swbr-refetch", 7'd0, 1'b0, eFetch(1'b0));

        // Reset arriving while a store is waiting in MEM.
        resetDut("rstmem-reset");
        applyStimulus("rstmem-idle", 7'd0, 1'b0, eIdle());
        applyStimulus("rstmem-fetch", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("rstmem-decode", 7'b0100011, 1'b0, eDecode());
        applyStimulus("rstmem-exec", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0));
        applyStimulus("rstmem-mem", 7'd0, 1'b0, eMemSw());
        #2;
        rst = 1'b1;
        #1;
        item.nm = "rstmem-async";
        item.v  = eIdle();
        expQ.push_back(item);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("rstmem-idle-after", 7'd0, 1'b0, eIdle());
        applyStimulus("rstmem-fetch-after", 7'd0, 1'b0, eFetch(1'b0));

        // Jump opcode on the jump-disabled instance traps and stays trapped.
        useT = 1'b1;
        resetDut("jal-reset");
        applyStimulus("jal-idle", 7'd0, 1'b0, eIdle());
        applyStimulus("jal-fetch", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("jal-decode", 7'b1101111, 1'b0, eDecode());
        applyStimulus("jal-trap", 7'b0110011, 1'b1, eTrap());
        applyStimulus("jal-trap-held1", 7'b0110011, 1'b0, eTrap());
        applyStimulus("jal-trap-held2", 7'b0000011, 1'b1, eTrap());
        resetDut("jal-clear");
        applyStimulus("jal-idle-after", 7'd0, 1'b0, eIdle());
        applyStimulus("jal-fetch-after", 7'd0, 1'b0, eFetch(1'b0));

        // Fetch timeout: the counter reads 0..4 over five waiting cycles; the
        // cycle with the counter at the limit and no mem_ready traps.
        resetDut("fto-reset");
        applyStimulus("fto-idle", 7'd0, 1'b0, eIdle());
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("fto-wait%0d", k), 7'd0, 1'b0, eFetch(1'b0));
        end
        applyStimulus("fto-trap", 7'd0, 1'b0, eTrap());

        // Same, but memory answers in the limit cycle: normal progress wins.
        resetDut("frdy-reset");
        applyStimulus("frdy-idle", 7'd0, 1'b0, eIdle());
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("frdy-wait%0d", k), 7'd0, 1'b0, eFetch(1'b0));
        end
        applyStimulus("frdy-limit-ready", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("frdy-decode", 7'b0110011, 1'b0, eDecode());
        applyStimulus("frdy-exec", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0));
        applyStimulus("frdy-wb", 7'd0, 1'b0, eWb(1'b0));

        // MEM timeout after a partly-waited fetch: the counter restarts on
        // entry to MEM, so MEM gets its own full five waiting cycles.
        resetDut("mto-reset");
        applyStimulus("mto-idle", 7'd0, 1'b0, eIdle());
        for (int k = 0; k < 3; k++) begin
            applyStimulus($sformatf("mto-fwait%0d", k), 7'd0, 1'b0, eFetch(1'b0));
        end
        applyStimulus("mto-fetch", 7'd0, 1'b1, eFetch(1'b1));
        applyStimulus("mto-decode", 7'b0000011, 1'b0, eDecode());
        applyStimulus("mto-exec", 7'd0, 1'b0,
                      mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0));
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("mto-mwait%0d", k), 7'd0, 1'b0, eMemLw());
        end
        applyStimulus("mto-trap", 7'd0, 1'b0, eTrap());

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
